// File: rtl/decoder_pkg.sv
// Shared types and constants for the sequenced 3-to-8 active-low decoder.
// Also provides the one-cold decode helper used by the top level.
package decoder_pkg;

   localparam int unsigned CODE_W   = 3;
   localparam int unsigned ONEHOT_W = 8;

   localparam logic [ONEHOT_W-1:0] IDLE_PATTERN = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      GAP
   } state_e;

   // Drives exactly one line low; all others stay at the idle (high) level.
   function automatic logic [ONEHOT_W-1:0] decode_low(input logic [CODE_W-1:0] c);
      logic [ONEHOT_W-1:0] o;
      o    = IDLE_PATTERN;
      o[c] = 1'b0;
      return o;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that times the hold phase of each decoded code.
// expire_o flags the final hold cycle (count of one).
module dwell_timer #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear_i,
   input  logic               load_i,
   input  logic [DWELL_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic [DWELL_W-1:0] value_o,
   output logic               expire_o
);

   logic [DWELL_W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - DWELL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign value_o  = count_q;
   assign expire_o = (count_q == DWELL_W'(1));

endmodule

// File: rtl/decoder3_8_seq.sv
// Sequenced 3-to-8 decoder: each accepted or scanned code pulls one line low for a
// programmable dwell, then a one-cycle all-high guard gap follows.
module decoder3_8_seq
   import decoder_pkg::*;
#(
   parameter int unsigned DWELL_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                E,
   input  logic                code_valid,
   output logic                code_ready,
   input  logic [CODE_W-1:0]   code,
   input  logic [DWELL_W-1:0]  dwell,
   input  logic                scan_en,
   output logic [ONEHOT_W-1:0] O,
   output logic                busy,
   output logic                done
);

   state_e              state_d, state_q;
   logic [CODE_W-1:0]   code_d, code_q;
   logic [CODE_W-1:0]   scan_ptr_d, scan_ptr_q;
   logic [DWELL_W-1:0]  dwell_eff;
   logic [DWELL_W-1:0]  timer_value;
   logic                timer_expire;
   logic                timer_load, timer_dec, timer_clear;

   assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      scan_ptr_d  = scan_ptr_q;
      timer_load  = 1'b0;
      timer_dec   = 1'b0;
      timer_clear = 1'b0;
      if (E) begin
         // Abort: drop straight to IDLE without a done pulse.
         state_d     = IDLE;
         timer_clear = 1'b1;
      end else begin
         case (state_q)
            IDLE, GAP: begin
               if (scan_en) begin
                  code_d     = scan_ptr_q;
                  scan_ptr_d = scan_ptr_q + CODE_W'(1);
                  timer_load = 1'b1;
                  state_d    = HOLD;
               end else if (code_valid) begin
                  code_d     = code;
                  timer_load = 1'b1;
                  state_d    = HOLD;
               end else begin
                  state_d = IDLE;
               end
            end
            HOLD: begin
               timer_dec = (timer_value != '0);
               if (timer_expire) begin
                  state_d = GAP;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         code_q     <= '0;
         scan_ptr_q <= '0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         scan_ptr_q <= scan_ptr_d;
      end
   end

   dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (timer_clear),
      .load_i     (timer_load),
      .load_val_i (dwell_eff),
      .dec_i      (timer_dec),
      .value_o    (timer_value),
      .expire_o   (timer_expire)
   );

   // rst_n gates ready so no handshake can complete while reset is held.
   always_comb begin
      code_ready = rst_n && !E && !scan_en && ((state_q == IDLE) || (state_q == GAP));
      busy       = !E && (state_q == HOLD);
      done       = !E && (state_q == GAP);
      O          = busy ? decode_low(code_q) : IDLE_PATTERN;
   end

endmodule

// File: tb/tb_decoder3_8_seq.sv
// Scenario bench for decoder3_8_seq: expected output traces are built from the
// dwell/gap timing rules and compared cycle by cycle.
module tb_decoder3_8_seq;

   logic       clk;
   logic       rst_n;
   logic       E;
   logic       code_valid;
   logic       code_ready;
   logic [2:0] code;
   logic [7:0] dwell;
   logic       scan_en;
   logic [7:0] O;
   logic       busy;
   logic       done;

   int total;
   int bad;
   logic [2:0] exp_scan;

   decoder3_8_seq #(
      .DWELL_W (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .E          (E),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .code       (code),
      .dwell      (dwell),
      .scan_en    (scan_en),
      .O          (O),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] low_of(input int k);
      return 8'hFF ^ (8'h01 << k);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      E          = 1'b0;
      code_valid = 1'b0;
      scan_en    = 1'b0;
      code       = 3'd0;
      dwell      = 8'd0;
      #23;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      E          = 1'b0;
      code_valid = 1'b1;
      scan_en    = 1'b0;
      code       = 3'd2;
      dwell      = 8'd1;
      #3;
      total++;
      if (O !== 8'hFF) begin bad++; $display("FAIL reset_o got=%h want=ff", O); end
      total++;
      if (code_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", code_ready); end
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done);
      end
      code_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (code_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", code_ready); end
      cyc();
   endtask

   task automatic test_single();
      do_reset();
      code       = 3'd3;
      dwell      = 8'd4;
      code_valid = 1'b1;
      cyc();
      code_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (O !== 8'hF7 || busy !== 1'b1) begin
            bad++; $display("FAIL single_hold%0d got=%h/%b want=f7/1", i, O, busy);
         end
         cyc();
      end
      @(negedge clk);
      total++;
      if (O !== 8'hFF || done !== 1'b1) begin
         bad++; $display("FAIL single_gap got=%h/%b want=ff/1", O, done);
      end
      cyc();
      @(negedge clk);
      total++;
      if (O !== 8'hFF || done !== 1'b0 || code_ready !== 1'b1) begin
         bad++; $display("FAIL single_idle got=%h/%b/%b want=ff/0/1", O, done, code_ready);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [2:0] ic[$];
      int         idw[$];
      logic [7:0] eo[$];
      bit         eacc[$];
      bit         edone[$];
      int         nxt;
      int         d;
      do_reset();
      ic.push_back(3'd0); idw.push_back(0);
      ic.push_back(3'd7); idw.push_back(0);
      ic.push_back(3'd5); idw.push_back(0);
      for (int i = 0; i < 6; i++) begin
         ic.push_back(3'($urandom_range(0, 7)));
         idw.push_back(int'($urandom_range(0, 4)));
      end
      eo.push_back(8'hFF); eacc.push_back(1'b1); edone.push_back(1'b0);
      for (int i = 0; i < ic.size(); i++) begin
         d = (idw[i] < 1) ? 1 : idw[i];
         for (int j = 0; j < d; j++) begin
            eo.push_back(low_of(int'(ic[i]))); eacc.push_back(1'b0); edone.push_back(1'b0);
         end
         eo.push_back(8'hFF); eacc.push_back(i + 1 < ic.size()); edone.push_back(1'b1);
      end
      nxt        = 0;
      code       = ic[0];
      dwell      = 8'(idw[0]);
      code_valid = 1'b1;
      for (int t = 0; t < eo.size(); t++) begin
         @(negedge clk);
         total++;
         if (O !== eo[t]) begin bad++; $display("FAIL b2b_o t=%0d got=%h want=%h", t, O, eo[t]); end
         total++;
         if (code_ready !== (eo[t] == 8'hFF) || busy !== (eo[t] != 8'hFF) || done !== edone[t]) begin
            bad++;
            $display("FAIL b2b_flags t=%0d got=%b%b%b want=%b%b%b", t, code_ready, busy, done,
                     eo[t] == 8'hFF, eo[t] != 8'hFF, edone[t]);
         end
         cyc();
         if (eacc[t]) begin
            nxt++;
            if (nxt < ic.size()) begin
               code  = ic[nxt];
               dwell = 8'(idw[nxt]);
            end else begin
               code_valid = 1'b0;
            end
         end
      end
      code_valid = 1'b0;
      @(negedge clk);
      total++;
      if (O !== 8'hFF || done !== 1'b0 || code_ready !== 1'b1) begin
         bad++; $display("FAIL b2b_end got=%h/%b/%b want=ff/0/1", O, done, code_ready);
      end
      cyc();
   endtask

   task automatic test_scan();
      logic [7:0] ex;
      int         loads;
      do_reset();
      scan_en = 1'b1;
      dwell   = 8'd2;
      loads   = 0;
      for (int t = 0; t < 30; t++) begin
         if (t == 0) begin
            ex = 8'hFF;
            loads++;
         end else if ((t - 1) % 3 < 2) begin
            ex = low_of(((t - 1) / 3) % 8);
         end else begin
            ex = 8'hFF;
            loads++;
         end
         @(negedge clk);
         total++;
         if (O !== ex) begin bad++; $display("FAIL scan_o t=%0d got=%h want=%h", t, O, ex); end
         total++;
         if (code_ready !== 1'b0) begin bad++; $display("FAIL scan_ready t=%0d got=%b want=0", t, code_ready); end
         cyc();
      end
      exp_scan = 3'(loads % 8);
      scan_en  = 1'b0;
      @(negedge clk);
      total++;
      if (O !== 8'hFF || done !== 1'b1) begin bad++; $display("FAIL scan_last_gap got=%h/%b want=ff/1", O, done); end
      cyc();
      @(negedge clk);
      total++;
      if (O !== 8'hFF || done !== 1'b0) begin bad++; $display("FAIL scan_stop got=%h/%b want=ff/0", O, done); end
      cyc();
   endtask

   task automatic test_abort();
      code       = 3'd6;
      dwell      = 8'd10;
      code_valid = 1'b1;
      cyc();
      code_valid = 1'b0;
      for (int h = 0; h < 2; h++) begin
         @(negedge clk);
         total++;
         if (O !== 8'hBF) begin bad++; $display("FAIL abort_hold%0d got=%h want=bf", h, O); end
         cyc();
      end
      total++;
      if (O !== 8'hBF) begin bad++; $display("FAIL abort_hold2 got=%h want=bf", O); end
      E          = 1'b1;
      code_valid = 1'b1;
      code       = 3'd1;
      dwell      = 8'd1;
      #1;
      total++;
      if (O !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || code_ready !== 1'b0) begin
         bad++; $display("FAIL abort_same_cycle got=%h/%b%b%b want=ff/000", O, busy, done, code_ready);
      end
      for (int i = 0; i < 12; i++) begin
         cyc();
         @(negedge clk);
         total++;
         if (O !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || code_ready !== 1'b0) begin
            bad++; $display("FAIL abort_held%0d got=%h/%b%b%b want=ff/000", i, O, busy, done, code_ready);
         end
      end
      cyc();
      E          = 1'b0;
      code_valid = 1'b0;
      #1;
      total++;
      if (code_ready !== 1'b1 || O !== 8'hFF) begin
         bad++; $display("FAIL abort_idle got=%h/%b want=ff/1", O, code_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (O !== 8'hFF || done !== 1'b0) begin
            bad++; $display("FAIL abort_after%0d got=%h/%b want=ff/0", i, O, done);
         end
         cyc();
      end
   endtask

   task automatic test_midhold_change();
      code       = 3'd2;
      dwell      = 8'd5;
      code_valid = 1'b1;
      cyc();
      code_valid = 1'b0;
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         total++;
         if (O !== 8'hFB || busy !== 1'b1) begin
            bad++; $display("FAIL mid_hold%0d got=%h/%b want=fb/1", h, O, busy);
         end
         if (h == 1) begin
            code       = 3'd7;
            dwell      = 8'd1;
            scan_en    = 1'b1;
            code_valid = 1'b1;
         end
         cyc();
      end
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         total++;
         if (O !== 8'hFF || done !== 1'b1) begin bad++; $display("FAIL mid_gap%0d got=%h/%b want=ff/1", s, O, done); end
         cyc();
         @(negedge clk);
         total++;
         if (O !== low_of(int'(exp_scan))) begin
            bad++; $display("FAIL mid_scan%0d got=%h want=%h", s, O, low_of(int'(exp_scan)));
         end
         exp_scan = exp_scan + 3'd1;
         if (s == 1) begin
            scan_en    = 1'b0;
            code_valid = 1'b0;
         end
         cyc();
      end
      @(negedge clk);
      total++;
      if (O !== 8'hFF || done !== 1'b1) begin bad++; $display("FAIL mid_end_gap got=%h/%b want=ff/1", O, done); end
      cyc();
      @(negedge clk);
      total++;
      if (O !== 8'hFF || done !== 1'b0 || code_ready !== 1'b1) begin
         bad++; $display("FAIL mid_end_idle got=%h/%b/%b want=ff/0/1", O, done, code_ready);
      end
      cyc();
   endtask

   task automatic test_reset_midhold();
      code       = 3'd4;
      dwell      = 8'd8;
      code_valid = 1'b1;
      cyc();
      code_valid = 1'b0;
      @(negedge clk);
      total++;
      if (O !== 8'hEF) begin bad++; $display("FAIL rstmid_hold got=%h want=ef", O); end
      cyc();
      cyc();
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (O !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || code_ready !== 1'b0) begin
         bad++; $display("FAIL rstmid_async got=%h/%b%b%b want=ff/000", O, busy, done, code_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (code_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", code_ready); end
      scan_en = 1'b1;
      dwell   = 8'd1;
      cyc();
      scan_en = 1'b0;
      @(negedge clk);
      total++;
      if (O !== 8'hFE) begin bad++; $display("FAIL rstmid_scan_ptr got=%h want=fe", O); end
      cyc();
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      exp_scan = 3'd0;
      test_reset();
      test_single();
      test_back_to_back();
      test_scan();
      test_abort();
      test_midhold_change();
      test_reset_midhold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
